// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM encoding, default depth, counter helper.
// Optional overflow counting is selected with UART_TX_FEEDER_OVF_CNT_EN (see uart_tx_feeder.sv).
package uart_tx_feeder_pkg;

  localparam int DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_WAIT_ACTIVE = 2'd2,
    ST_WAIT_DONE   = 2'd3
  } feeder_state_t;

  localparam logic [7:0] OVF_MAX = 8'hFF;

  // Saturating 8-bit increment used by the dropped-write counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == OVF_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Signal bundle between the byte writer, the feeder and the UART transmitter.
// master = feeder side, slave = application/transmitter side.
interface uart_tx_feeder_if
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr_dv;
  logic [7:0]        wr_byte;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active;
  logic              tx_done;
  logic [7:0]        ovf_count;

  modport master (
    input  wr_dv,
    input  wr_byte,
    output full,
    output empty,
    output count,
    output tx_dv,
    output tx_byte,
    input  tx_active,
    input  tx_done,
    output ovf_count
  );

  modport slave (
    output wr_dv,
    output wr_byte,
    input  full,
    input  empty,
    input  count,
    input  tx_dv,
    input  tx_byte,
    output tx_active,
    output tx_done,
    input  ovf_count
  );

endinterface

// File: rtl/uart_tx_feeder_sync_byte_fifo.sv
// Single-clock byte FIFO with registered full/empty/count; occupancy comes from an
// explicit counter so pointer wrap never confuses full with empty.
module sync_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic                     pop,
  input  logic [7:0]               wr_data,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              do_wr;
  logic              do_pop;

  // Gating uses the registered flags, so a write into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign do_wr  = wr & ~full_reg;
  assign do_pop = pop & ~empty_reg;

  always_comb begin
    count_next = count_reg;
    if (do_wr && !do_pop) begin
      count_next = count_reg + COUNT_ONE;
    end else if (!do_wr && do_pop) begin
      count_next = count_reg - COUNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == COUNT_FULL);
      empty_reg <= (count_next == '0);
    end
  end

  // Storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign count   = count_reg;

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte-buffering front end for a UART transmitter: FIFO plus an issue FSM that strobes one byte
// per frame. Define UART_TX_FEEDER_OVF_CNT_EN to enable the saturating dropped-write counter.
module uart_tx_feeder
  import uart_tx_feeder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_feeder_if.master   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  feeder_state_t   state_reg;
  feeder_state_t   state_next;
  logic            tx_dv_reg;
  logic            tx_dv_next;
  logic [7:0]      tx_byte_reg;
  logic [7:0]      tx_byte_next;
  logic            pop;
  logic [7:0]      fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;

  sync_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (bus.wr_dv),
    .pop     (pop),
    .wr_data (bus.wr_byte),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The transmitter is not reset with us and may still be finishing a frame, so IDLE
  // waits for both active and done to be low before it issues anything.
  always_comb begin
    state_next   = state_reg;
    tx_dv_next   = 1'b0;
    tx_byte_next = tx_byte_reg;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty && !bus.tx_active && !bus.tx_done) begin
          pop          = 1'b1;
          tx_dv_next   = 1'b1;
          tx_byte_next = fifo_head;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_ACTIVE;
      end
      ST_WAIT_ACTIVE: begin
        if (bus.tx_active) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_active) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      tx_dv_reg   <= 1'b0;
      tx_byte_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      tx_dv_reg   <= tx_dv_next;
      tx_byte_reg <= tx_byte_next;
    end
  end

`ifdef UART_TX_FEEDER_OVF_CNT_EN
  logic [7:0] ovf_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 8'h00;
    end else if (bus.wr_dv && fifo_full) begin
      ovf_reg <= sat_inc8(ovf_reg);
    end
  end

  assign bus.ovf_count = ovf_reg;
`else
  assign bus.ovf_count = 8'h00;
`endif

  assign bus.full    = fifo_full;
  assign bus.empty   = fifo_empty;
  assign bus.count   = fifo_count;
  assign bus.tx_dv   = tx_dv_reg;
  assign bus.tx_byte = tx_byte_reg;

endmodule
